ahb_master: RTL and testbench
=============================

AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: wait-state cycles with hready low before a transfer is aborted; legal range 2..255.
REQ-002 clk  in  1  clock; all state changes on its rising edge.
REQ-003 hresetn  in  1  reset: asynchronous, active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  32  byte address; bits [1:0] ignored and forced to 0 on haddr.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  one-cycle pulse: transfer finished.
REQ-010 rsp_rdata  out  32  read data; valid while rsp_valid is high on a read.
REQ-011 rsp_err  out  1  slave ERROR or timeout; valid with rsp_valid.
REQ-012 rsp_timeout  out  1  abort caused by timeout; valid with rsp_valid.
REQ-013 txn_count  out  16  count of rsp_valid pulses; wraps 0xFFFF -> 0x0000.
REQ-014 hsel, htrans[1:0], hwrite, hsize[2:0], hburst[2:0], haddr[31:0], hwdata[31:0]  out  AHB master-side signals, all registered.
REQ-015 hready, hresp, hrdata[31:0]  in  AHB slave responses.

Function
REQ-016 The FSM shall have states IDLE, ADDR, DATA; only single transfers: hsize=3'b010, hburst=3'b000 whenever hsel=1.
REQ-017 In IDLE: cmd_ready=1; hsel=0; htrans=IDLE (2'b00).
REQ-018 On a clock edge with cmd_valid=1 and cmd_ready=1: latch command, go to ADDR; haddr, hwrite, hwdata, hsel=1, htrans=NONSEQ (2'b10) are valid from the next cycle.
REQ-019 cmd_ready shall be 0 in ADDR and DATA; cmd_valid is ignored there.
REQ-020 ADDR: on an edge with hready=1, go to DATA and drive htrans=IDLE, hsel=0; with hready=0, hold all AHB outputs unchanged.
REQ-021 hwdata shall be held stable from the first ADDR cycle until DATA completes.
REQ-022 DATA: on an edge with hready=1, capture hrdata into rsp_rdata (reads only; writes leave rsp_rdata unchanged) and hresp into rsp_err; pulse rsp_valid for the next cycle; return to IDLE.
REQ-023 rsp_timeout=0 on normal completion; txn_count shall increment by 1 in the cycle rsp_valid is high.
REQ-024 A wait counter shall clear on entry to ADDR and DATA and increment on every edge with hready=0 in either state.
REQ-025 When the counter reaches TIMEOUT, abort: htrans=IDLE, hsel=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata unchanged; go to IDLE.
REQ-026 If hready=1 arrives on the same edge the counter reaches TIMEOUT, normal completion shall win.
REQ-027 Earliest next command acceptance shall be the cycle in which rsp_valid is high, since cmd_ready=1 in IDLE.

Reset
REQ-028 While hresetn=0: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, txn_count=0, hsel=0, htrans=2'b00, hwrite=0, hsize=3'b010, hburst=0, haddr=0, hwdata=0, wait counter=0.
REQ-029 Reset asserted mid-transfer shall drop the transfer with no rsp_valid pulse.

Verification
REQ-030 Write cmd addr=0x10, wdata=0xCAFEF00D to a slave with one wait state -> NONSEQ for 1 cycle, hwdata stable to completion, rsp_valid 3 cycles after the handshake edge, rsp_err=0, txn_count=1.
REQ-031 Read back addr=0x10 -> rsp_rdata=0xCAFEF00D, rsp_err=0; cmd_valid held high throughout -> second handshake in the rsp_valid cycle.
REQ-032 Slave returns hresp=1 at data completion -> rsp_err=1, rsp_timeout=0.
REQ-033 hready held 0 for the whole DATA phase with TIMEOUT=4 -> abort after 4 low edges, rsp_err=1, rsp_timeout=1, FSM back in IDLE.
REQ-034 hresetn pulsed low during ADDR -> all outputs at reset values, no rsp_valid, next command completes normally.
REQ-035 Preload txn_count to 0xFFFF (65535 transfers or force) then one transfer -> txn_count=0x0000.

Source files
------------

// File: rtl/ahb_master.sv
// Single-transfer AHB-Lite master: one command in, one NONSEQ word transfer out.
// Wait states are bounded by TIMEOUT; an expired bound aborts with an error response.
module ahb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [15:0] txn_count,
  output logic        hsel,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_e      state_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        rsp_timeout_q;
  logic [15:0] txn_count_q;
  logic        hsel_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [31:0] haddr_q;
  logic [31:0] hwdata_q;
  logic [7:0]  wait_q;
  logic [7:0]  wait_d;
  logic        timeout_hit;
  logic        unused_addr_lsb;

  assign wait_d          = wait_q + 8'd1;
  // A ready slave always wins over the timeout on the same edge.
  assign timeout_hit     = !hready && (wait_d == 8'(TIMEOUT));
  assign unused_addr_lsb = ^cmd_addr[1:0];

  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      txn_count_q   <= 16'h0;
      hsel_q        <= 1'b0;
      htrans_q      <= HTRANS_IDLE;
      hwrite_q      <= 1'b0;
      haddr_q       <= 32'h0;
      hwdata_q      <= 32'h0;
      wait_q        <= 8'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q     <= S_ADDR;
            cmd_ready_q <= 1'b0;
            hsel_q      <= 1'b1;
            htrans_q    <= HTRANS_NONSEQ;
            hwrite_q    <= cmd_write;
            haddr_q     <= {cmd_addr[31:2], 2'b00};
            hwdata_q    <= cmd_wdata;
            wait_q      <= 8'h0;
          end
        end
        S_ADDR, S_DATA: begin
          if (hready) begin
            wait_q <= 8'h0;
            if (state_q == S_ADDR) begin
              state_q  <= S_DATA;
              hsel_q   <= 1'b0;
              htrans_q <= HTRANS_IDLE;
            end else begin
              state_q       <= S_IDLE;
              cmd_ready_q   <= 1'b1;
              rsp_valid_q   <= 1'b1;
              rsp_err_q     <= hresp;
              rsp_timeout_q <= 1'b0;
              txn_count_q   <= txn_count_q + 16'd1;
              if (!hwrite_q) begin
                rsp_rdata_q <= hrdata;
              end
            end
          end else if (timeout_hit) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            hsel_q        <= 1'b0;
            htrans_q      <= HTRANS_IDLE;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            txn_count_q   <= txn_count_q + 16'd1;
            wait_q        <= 8'h0;
          end else begin
            wait_q <= wait_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign txn_count   = txn_count_q;
  assign hsel        = hsel_q;
  assign htrans      = htrans_q;
  assign hwrite      = hwrite_q;
  assign hsize       = 3'b010;
  assign hburst      = 3'b000;
  assign haddr       = haddr_q;
  assign hwdata      = hwdata_q;

endmodule

// File: tb/tb_ahb_master.sv
// Randomized bench for ahb_master against a transaction-level model
// with a small word memory acting as the AHB slave.
module tb_ahb_master;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] txn_count;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem [16];
  logic [31:0] m_rdata;
  logic [15:0] m_cnt;

  ahb_master #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .hresetn    (hresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .txn_count  (txn_count),
    .hsel       (hsel),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .hready     (hready),
    .hresp      (hresp),
    .hrdata     (hrdata)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_txn_count", txn_count, 0);
    check("rst_hsel", hsel, 0);
    check("rst_htrans", htrans, 0);
    check("rst_hwrite", hwrite, 0);
    check("rst_hsize", hsize, 3'b010);
    check("rst_hburst", hburst, 0);
    check("rst_haddr", haddr, 0);
    check("rst_hwdata", hwdata, 0);
  endtask

  // aw/dw: hready-low edges in address/data phase; resp: hresp at data completion.
  task automatic run_txn(bit b2b, bit wr, logic [31:0] addr,
                         logic [31:0] wdata, int aw, int dw, bit resp);
    int          lat;
    int          k;
    bit          to;
    bit          done;
    logic [31:0] exp_rd;
    logic [3:0]  idx;
    idx = addr[5:2];
    if (aw >= T) begin
      to  = 1'b1;
      lat = T;
    end else if (dw >= T) begin
      to  = 1'b1;
      lat = aw + 1 + T;
    end else begin
      to  = 1'b0;
      lat = aw + dw + 2;
    end
    if (!b2b) @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    hready    = (aw == 0);
    hresp     = 1'b0;
    @(negedge clk);
    check("rsp_pulse_end", rsp_valid, 0);
    done = 1'b0;
    k    = 1;
    while (!done && k <= lat + 3) begin
      if (rsp_valid) begin
        done = 1'b1;
        m_cnt++;
        exp_rd = (!to && !wr) ? mem[idx] : m_rdata;
        check("latency", k - 1, lat);
        check("rsp_err", rsp_err, to ? 1'b1 : resp);
        check("rsp_timeout", rsp_timeout, to);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("txn_count", txn_count, m_cnt);
        check("rsp_cmd_ready", cmd_ready, 1);
        check("rsp_hsel", hsel, 0);
        check("rsp_htrans", htrans, 0);
        m_rdata = exp_rd;
        if (!to && wr && !resp) mem[idx] = wdata;
        cmd_valid = 1'b0;
      end else begin
        if (k <= aw + 1) begin
          check("addr_htrans", htrans, 2'b10);
          check("addr_hsel", hsel, 1);
          check("addr_haddr", haddr, {addr[31:2], 2'b00});
          check("addr_hwrite", hwrite, wr);
          if (k == 1) begin
            check("addr_hsize", hsize, 3'b010);
            check("addr_hburst", hburst, 0);
          end
        end else begin
          check("data_htrans", htrans, 0);
          check("data_hsel", hsel, 0);
        end
        check("hwdata_hold", hwdata, wdata);
        check("busy_cmd_ready", cmd_ready, 0);
        hready = (k == aw + 1) || (k == aw + dw + 2);
        if (k == aw + dw + 2) begin
          hresp  = resp;
          hrdata = wr ? $urandom : mem[idx];
        end else begin
          hresp  = 1'($urandom % 2);
          hrdata = $urandom;
        end
        cmd_valid = 1'($urandom % 2);
        cmd_write = 1'($urandom % 2);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        @(negedge clk);
        k++;
      end
    end
    if (!done) begin
      check("rsp_seen", 0, 1);
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    hresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h0;
    m_cnt     = 16'h0;
    m_rdata   = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    #12;
    chk_reset_vals();
    @(negedge clk);
    hresetn = 1'b1;

    run_txn(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 0, 1, 1'b0);
    check("first_wr_count", txn_count, 1);
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 0, 0, 1'b0);
    check("readback", rsp_rdata, 32'hCAFEF00D);
    run_txn(1'b0, 1'b0, 32'h20, 32'h0, 1, 0, 1'b1);
    run_txn(1'b0, 1'b0, 32'h30, 32'h0, 0, T, 1'b0);
    run_txn(1'b1, 1'b1, 32'h34, 32'h12345678, T + 1, 0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h38, 32'h0, 0, T - 1, 1'b0);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h44;
    cmd_wdata = $urandom;
    hready    = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_htrans", htrans, 2'b10);
    #2 hresetn = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    hresetn = 1'b1;
    m_cnt   = 16'h0;
    m_rdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("no_rsp_after_rst", rsp_valid, 0);
      check("idle_after_rst", cmd_ready, 1);
    end
    hready = 1'b1;
    run_txn(1'b0, 1'b1, 32'h48, 32'hA5A55A5A, 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h48, 32'h0, 1, 2, 1'b0);

    @(negedge clk);
    force dut.txn_count_q = 16'hFFFF;
    #1 release dut.txn_count_q;
    m_cnt = 16'hFFFF;
    check("preload_count", txn_count, 16'hFFFF);
    run_txn(1'b0, 1'b0, 32'h4, 32'h0, 0, 0, 1'b0);
    check("count_wrap", txn_count, 16'h0000);

    for (int i = 0; i < 40; i++) begin
      int aw;
      int dw;
      aw = ($urandom % 6 == 0) ? T : int'($urandom_range(0, 2));
      dw = int'($urandom_range(0, T));
      run_txn(1'($urandom % 2), 1'($urandom % 2), $urandom, $urandom,
              aw, dw, 1'($urandom % 4 == 0));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
